// File: rtl/nibble_serial_add_ctrl.sv
// Serial WIDTH-bit adder sequencer driving one external 4-bit CLA slice, LSB nibble first.
// Optional macro NIBBLE_ADD_SUB_EN adds a 'sub' input for a - b via the same slice.
module nibble_serial_add_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef NIBBLE_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [3:0]       add_x,
  output logic [3:0]       add_y,
  output logic             add_c0,
  input  logic [3:0]       add_f,
  input  logic             add_c4
);

  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned CW  = $clog2(NIB);
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

`ifdef NIBBLE_ADD_SUB_EN
  // Subtraction is a + ~b + 1; cout=1 then means no borrow.
  assign b_load = sub ? ~b : b;
  assign c_load = sub ? 1'b1 : cin;
`else
  assign b_load = b;
  assign c_load = cin;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    done       = 1'b0;
    add_x      = '0;
    add_y      = '0;
    add_c0     = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_next = RUN;
      end
      RUN: begin
        add_x  = a_reg[3:0];
        add_y  = b_reg[3:0];
        add_c0 = carry;
        if (cnt == LAST) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= b_load;
            carry <= c_load;
            cnt   <= '0;
          end
        end
        RUN: begin
          // Result nibbles enter at the top so the LSB nibble lands at bit 0 after NIB shifts.
          sum   <= {add_f, sum[WIDTH-1:4]};
          a_reg <= a_reg >> 4;
          b_reg <= b_reg >> 4;
          carry <= add_c4;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) cout <= add_c4;
        end
        default: ;
      endcase
    end
  end

endmodule
